// File: rtl/fetch_pkg.sv
// Shared types, default widths and the assembler-generated branch-target table
// for the program-counter / fetch sequencer.
package fetch_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int LUT_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Absolute bne targets; regenerated together with the ROM image.
  localparam logic [PC_W_DEF-1:0] BR_TARGETS [2**LUT_W_DEF] = '{
    10'd100, 10'd200, 10'd5,   10'd40,
    10'd300, 10'd17,  10'd512, 10'd1023,
    10'd64,  10'd2,   10'd900, 10'd33,
    10'd128, 10'd700, 10'd250, 10'd1
  };

endpackage

// File: rtl/prog_fetch_branch_lut.sv
// Combinational branch-target lookup: lut_idx -> absolute pc, resized to PC_W
// (zero-extended when PC_W is wider than the table, truncated when narrower).
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF
) (
  input  logic [LUT_W-1:0] lut_idx_i,
  output logic [PC_W-1:0]  target_o
);

  assign target_o = PC_W'(BR_TARGETS[lut_idx_i]);

endmodule

// File: rtl/prog_fetch.sv
// Program counter and fetch sequencer: IDLE -> RUN -> HALTED, one instruction per
// cycle with 0-wait ROM, bne redirect through the target LUT, saturating RUN-cycle count.
module prog_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             branch_i,
  input  logic             alu_zero_i,
  input  logic             halt_i,
  input  logic [LUT_W-1:0] lut_idx_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             running_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  br_target;

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_lut (
    .lut_idx_i (lut_idx_i),
    .target_o  (br_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start_i) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Halt freezes pc on the halt instruction, even if a branch is decoded too.
        if (halt_i) begin
          state_d = HALTED;
        end else if (branch_i && !alu_zero_i) begin
          pc_d = br_target;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign running_o   = (state_q == RUN);
  assign done_o      = (state_q == HALTED);
  assign cycle_cnt_o = cnt_q;

endmodule
